// File: rtl/ncc_seq_ctrl.sv
// ncc_seq_ctrl: sequencer for the ncc PE and its log2 front end.
// Streams descriptor then window pixels into the PE lanes, strobes the PE
// load registers, scans NUM_WIN candidate windows and tracks the best score.
// Optional feature macro: NCC_SEQ_EARLY_EXIT_EN (stop the scan once a window
// score reaches score_thresh; adds ports score_thresh and early_exit).
module ncc_seq_ctrl #(
    parameter int unsigned NPIX    = 8,
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned NUM_WIN = 16,
    parameter int unsigned ACC_LAT = 2,
    localparam int unsigned IDX_W  = (NPIX > 1) ? $clog2(NPIX) : 1,
    localparam int unsigned WIN_W  = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    output logic               pix_ready,
    output logic [PIX_W-1:0]   log_din,
    output logic               desc_wr,
    output logic               win_wr,
    output logic [IDX_W-1:0]   wr_idx,
    output logic               loadWinReg,
    output logic               loadAccSumReg,
`ifdef NCC_SEQ_EARLY_EXIT_EN
    input  logic [SCORE_W-1:0] score_thresh,
    output logic               early_exit,
`endif
    input  logic [SCORE_W-1:0] acc_out,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] best_score,
    output logic [WIN_W-1:0]   best_idx
);

    // WAIT holds for ACC_LAT-1 cycles; lat_cnt runs 0..ACC_LAT-2
    localparam int unsigned LAT_W    = (ACC_LAT > 2) ? $clog2(ACC_LAT - 1) : 1;
    localparam int unsigned LAT_LAST = (ACC_LAT > 1) ? (ACC_LAT - 2) : 0;
    localparam bit          HAS_WAIT = (ACC_LAT > 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_DESC = 3'd1,
        S_LOAD_WIN  = 3'd2,
        S_WIN_LD    = 3'd3,
        S_ACC       = 3'd4,
        S_WAIT      = 3'd5,
        S_CMP       = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   cnt;
    logic [WIN_W-1:0]   win_idx;
    logic [LAT_W-1:0]   lat_cnt;

    logic               load_st;
    logic               beat;
    logic               last_beat;
    logic               last_win;
    logic               wait_done;
    logic               take_best;
    logic               thresh_hit;

    assign log_din   = pix_data;
    assign load_st   = (state == S_LOAD_DESC) || (state == S_LOAD_WIN);
    assign beat      = load_st && pix_valid;
    assign last_beat = (cnt == IDX_W'(NPIX - 1));
    assign last_win  = (win_idx == WIN_W'(NUM_WIN - 1));
    assign wait_done = (lat_cnt == LAT_W'(LAT_LAST));
    // window 0 is always captured so the result never reflects a stale search
    assign take_best = (win_idx == '0) || (acc_out > best_score);

`ifdef NCC_SEQ_EARLY_EXIT_EN
    assign thresh_hit = (acc_out >= score_thresh);
`else
    assign thresh_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_LOAD_DESC;
            S_LOAD_DESC: if (beat && last_beat) state_nxt = S_LOAD_WIN;
            S_LOAD_WIN:  if (beat && last_beat) state_nxt = S_WIN_LD;
            S_WIN_LD:    state_nxt = S_ACC;
            S_ACC:       state_nxt = HAS_WAIT ? S_WAIT : S_CMP;
            S_WAIT:      if (wait_done) state_nxt = S_CMP;
            S_CMP:       state_nxt = (last_win || thresh_hit) ? S_DONE : S_LOAD_WIN;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode; lane writes qualify the current beat
    always_comb begin
        pix_ready     = 1'b0;
        desc_wr       = 1'b0;
        win_wr        = 1'b0;
        wr_idx        = '0;
        loadWinReg    = 1'b0;
        loadAccSumReg = 1'b0;
        busy          = (state != S_IDLE);
        done          = 1'b0;
        case (state)
            S_LOAD_DESC: begin
                pix_ready = 1'b1;
                desc_wr   = pix_valid;
                wr_idx    = cnt;
            end
            S_LOAD_WIN: begin
                pix_ready = 1'b1;
                win_wr    = pix_valid;
                wr_idx    = cnt;
            end
            S_WIN_LD: loadWinReg    = 1'b1;
            S_ACC:    loadAccSumReg = 1'b1;
            S_DONE:   done          = 1'b1;
            default: ;
        endcase
    end

    // Beat, window and latency counters plus best-score tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            win_idx    <= '0;
            lat_cnt    <= '0;
            best_score <= '0;
            best_idx   <= '0;
`ifdef NCC_SEQ_EARLY_EXIT_EN
            early_exit <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt        <= '0;
                        win_idx    <= '0;
                        best_score <= '0;
                        best_idx   <= '0;
`ifdef NCC_SEQ_EARLY_EXIT_EN
                        early_exit <= 1'b0;
`endif
                    end
                end
                S_LOAD_DESC, S_LOAD_WIN: begin
                    if (beat) begin
                        cnt <= last_beat ? '0 : cnt + IDX_W'(1);
                    end
                end
                S_ACC:  lat_cnt <= '0;
                S_WAIT: lat_cnt <= lat_cnt + LAT_W'(1);
                S_CMP: begin
                    if (take_best) begin
                        best_score <= acc_out;
                        best_idx   <= win_idx;
                    end
                    if (!last_win && !thresh_hit) begin
                        win_idx <= win_idx + WIN_W'(1);
                    end
`ifdef NCC_SEQ_EARLY_EXIT_EN
                    if (thresh_hit) begin
                        early_exit <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ncc_seq_ctrl.sv
// tb_ncc_seq_ctrl: scoreboard bench for ncc_seq_ctrl (NPIX=8, NUM_WIN=4, ACC_LAT=2).
// A small ncc model returns a window score exactly ACC_LAT cycles after each
// loadAccSumReg pulse and an all-ones value otherwise.
module tb_ncc_seq_ctrl;

    localparam int unsigned NPIX    = 8;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned NUM_WIN = 4;
    localparam int unsigned ACC_LAT = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               pix_valid = 1'b0;
    logic [PIX_W-1:0]   pix_data = '0;
    logic               pix_ready;
    logic [PIX_W-1:0]   log_din;
    logic               desc_wr;
    logic               win_wr;
    logic [2:0]         wr_idx;
    logic               loadWinReg;
    logic               loadAccSumReg;
    logic [SCORE_W-1:0] acc_out;
    logic               busy;
    logic               done;
    logic [SCORE_W-1:0] best_score;
    logic [1:0]         best_idx;
`ifdef NCC_SEQ_EARLY_EXIT_EN
    logic [SCORE_W-1:0] score_thresh = '0;
    logic               early_exit;
`endif

    always #5 clk = ~clk;

    ncc_seq_ctrl #(
        .NPIX(NPIX), .PIX_W(PIX_W), .SCORE_W(SCORE_W),
        .NUM_WIN(NUM_WIN), .ACC_LAT(ACC_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .log_din(log_din), .desc_wr(desc_wr), .win_wr(win_wr), .wr_idx(wr_idx),
        .loadWinReg(loadWinReg), .loadAccSumReg(loadAccSumReg),
`ifdef NCC_SEQ_EARLY_EXIT_EN
        .score_thresh(score_thresh), .early_exit(early_exit),
`endif
        .acc_out(acc_out), .busy(busy), .done(done),
        .best_score(best_score), .best_idx(best_idx)
    );

    typedef struct { logic [SCORE_W-1:0] score; logic [1:0] idx; logic ee; } res_t;
    typedef struct { logic kind; logic [2:0] lane; } wr_t;

    res_t               exp_q[$];
    wr_t                wr_q[$];
    logic [SCORE_W-1:0] scores [NUM_WIN];
    int                 n_checks = 0;
    int                 n_fail = 0;
    logic               beat_now = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ncc model: score for window k appears exactly two cycles after its strobe
    logic [SCORE_W-1:0] sc0 = '0, sc1 = '0;
    logic               p0 = 1'b0, p1 = 1'b0;
    int                 acc_k = 0;
    always @(posedge clk) begin
        p0  <= loadAccSumReg;
        p1  <= p0;
        sc1 <= sc0;
        if (start && !busy) acc_k <= 0;
        else if (loadAccSumReg) begin
            sc0   <= scores[acc_k % NUM_WIN];
            acc_k <= acc_k + 1;
        end
    end
    assign acc_out = p1 ? sc1 : 16'hFFFF;

    int   cyc = 0;
    int   t_last = -100;
    int   n_lwr = 0, n_lasr = 0, n_done = 0, n_winwr = 0;
    logic prev_lwr = 1'b0, prev_lasr = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: lane writes, strobe timing and end-of-search results
    always @(negedge clk) begin
        wr_t  w;
        res_t r;
        check_eq("wr_strobe", 32'(desc_wr | win_wr), 32'(beat_now));
        check_eq("wr_exclusive", 32'(desc_wr & win_wr), 0);
        if (!pix_ready) check_eq("wr_idx_idle", 32'(wr_idx), 0);
        if (desc_wr | win_wr) begin
            if (wr_q.size() == 0) begin
                check_eq("wr_unexpected", 32'(desc_wr | win_wr), 0);
            end else begin
                w = wr_q.pop_front();
                check_eq("wr_kind", 32'(win_wr), 32'(w.kind));
                check_eq("wr_idx", 32'(wr_idx), 32'(w.lane));
                if (w.kind && w.lane == 3'd7) t_last = cyc;
            end
        end
        if (win_wr) n_winwr++;
        if (loadWinReg) begin
            n_lwr++;
            check_eq("lwr_single", 32'(prev_lwr), 0);
            check_eq("lwr_time", cyc, t_last + 1);
        end
        if (loadAccSumReg) begin
            n_lasr++;
            check_eq("lasr_single", 32'(prev_lasr), 0);
            check_eq("lasr_time", cyc, t_last + 2);
        end
        if (done) begin
            n_done++;
            check_eq("done_time", cyc, t_last + 5);
            if (exp_q.size() == 0) begin
                check_eq("done_unexpected", 32'(done), 0);
            end else begin
                r = exp_q.pop_front();
                check_eq("best_score", 32'(best_score), 32'(r.score));
                check_eq("best_idx", 32'(best_idx), 32'(r.idx));
`ifdef NCC_SEQ_EARLY_EXIT_EN
                check_eq("early_exit", 32'(early_exit), 32'(r.ee));
`endif
            end
        end
        prev_lwr  = loadWinReg;
        prev_lasr = loadAccSumReg;
    end

    // Reference: strict-greater tracking, window 0 forced, optional threshold stop
    task automatic push_expected(input logic [SCORE_W-1:0] thr, input logic use_thr,
                                 output int nwin);
        res_t r;
        r.score = '0; r.idx = '0; r.ee = 1'b0;
        nwin = NUM_WIN;
        for (int w = 0; w < NUM_WIN; w++) begin
            if (w == 0 || scores[w] > r.score) begin
                r.score = scores[w];
                r.idx   = 2'(w);
            end
            if (use_thr && scores[w] >= thr) begin
                r.ee = 1'b1;
                nwin = w + 1;
                break;
            end
        end
        exp_q.push_back(r);
    endtask

    task automatic start_search;
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // Offer n beats; gappy inserts an idle cycle after each beat; start pulsed at beat start_at
    task automatic feed(input int n, input bit gappy, input int start_at);
        int fed = 0;
        int guard = 0;
        bit skip = 1'b0;
        bit injected = 1'b0;
        while (fed < n && guard < 2000) begin
            @(posedge clk); #2;
            guard++;
            start = 1'b0;
            if (!injected && fed == start_at) begin
                start    = 1'b1;
                injected = 1'b1;
            end
            if (gappy && skip) begin
                pix_valid = 1'b0;
                beat_now  = 1'b0;
                skip      = 1'b0;
            end else begin
                pix_valid = 1'b1;
                pix_data  = 8'($urandom);
                if (pix_ready) begin
                    beat_now = 1'b1;
                    wr_q.push_back('{kind: (fed >= int'(NPIX)), lane: 3'(fed % NPIX)});
                    fed++;
                    skip = 1'b1;
                end else begin
                    beat_now = 1'b0;
                end
            end
        end
        @(posedge clk); #2;
        pix_valid = 1'b0;
        beat_now  = 1'b0;
        start     = 1'b0;
        check_eq("beats_fed", fed, n);
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 50; i++) begin
            if (!busy) break;
            @(posedge clk); #2;
        end
        check_eq("search_end", 32'(busy), 0);
    endtask

    // Full search with scoreboarded results and strobe counts
    task automatic run_search(input string tag, input bit gappy, input int start_at,
                              input logic [1:0] e_idx, input logic [SCORE_W-1:0] e_score);
        int d0, l0, a0, nwin;
        d0 = n_done; l0 = n_lwr; a0 = n_lasr;
        push_expected('0, 1'b0, nwin);
        start_search();
        feed(NPIX * (NUM_WIN + 1), gappy, start_at);
        wait_idle();
        check_eq({tag, "_done_cnt"}, n_done - d0, 1);
        check_eq({tag, "_lwr_cnt"}, n_lwr - l0, nwin);
        check_eq({tag, "_lasr_cnt"}, n_lasr - a0, nwin);
        check_eq({tag, "_hold_score"}, 32'(best_score), 32'(e_score));
        check_eq({tag, "_hold_idx"}, 32'(best_idx), 32'(e_idx));
    endtask

    initial begin
        int d0;
        int w0;
        int nwin;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_ready", 32'(pix_ready), 0);
        check_eq("rst_best_score", 32'(best_score), 0);
        check_eq("rst_best_idx", 32'(best_idx), 0);
        rst = 1'b1;

        scores = '{16'd10, 16'd30, 16'd20, 16'd30};
        run_search("tie", 1'b0, 20, 2'd1, 16'd30);

        scores = '{16'd5, 16'd7, 16'd7, 16'd2};
        run_search("gappy", 1'b1, -1, 2'd1, 16'd7);

        scores = '{16'd0, 16'd0, 16'd0, 16'd0};
        run_search("zeros", 1'b0, 5, 2'd0, 16'd0);

        scores = '{16'd50, 16'd40, 16'd60, 16'd60};
        run_search("late", 1'b0, -1, 2'd2, 16'd60);

        // Abort mid-window: reset while window lane 3 is next
        scores = '{16'd900, 16'd1, 16'd2, 16'd3};
        push_expected('0, 1'b0, nwin);
        d0 = n_done;
        start_search();
        feed(NPIX + 3, 1'b0, -1);
        rst = 1'b0;
        @(posedge clk); #2;
        exp_q.delete();
        wr_q.delete();
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_score", 32'(best_score), 0);
        check_eq("abort_idx", 32'(best_idx), 0);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        check_eq("abort_no_done", n_done - d0, 0);
        check_eq("abort_idle", 32'(busy), 0);

`ifdef NCC_SEQ_EARLY_EXIT_EN
        score_thresh = 16'd25;
        scores = '{16'd10, 16'd30, 16'd5, 16'd40};
        push_expected(16'd25, 1'b1, nwin);
        w0 = n_winwr;
        d0 = n_done;
        start_search();
        check_eq("ee_clear_on_start", 32'(early_exit), 0);
        feed(NPIX * (nwin + 1), 1'b0, -1);
        wait_idle();
        repeat (4) @(posedge clk);
        #2;
        check_eq("ee_win_wr", n_winwr - w0, 2 * NPIX);
        check_eq("ee_done_cnt", n_done - d0, 1);
        check_eq("ee_hold", 32'(early_exit), 1);
        check_eq("ee_idx", 32'(best_idx), 1);
        score_thresh = 16'hFFFF;
        scores = '{16'd3, 16'd1, 16'd4, 16'd1};
        push_expected(16'hFFFF, 1'b1, nwin);
        start_search();
        check_eq("ee_cleared", 32'(early_exit), 0);
        feed(NPIX * (nwin + 1), 1'b0, -1);
        wait_idle();
`else
        w0 = n_winwr;
        scores = '{16'd8, 16'd9, 16'd1, 16'd9};
        run_search("full", 1'b0, -1, 2'd1, 16'd9);
        check_eq("full_win_wr", n_winwr - w0, NUM_WIN * NPIX);
`endif

        check_eq("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
